// File: rtl/count_pwm_gen.sv
// PWM generator driven by an upstream free-running up-counter: double-buffered
// duty, wrap/match strobes and a sticky period interrupt flag.
module count_pwm_gen #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_in,
   input  logic             count_en,
   input  logic [WIDTH-1:0] duty_in,
   input  logic             duty_load,
   input  logic             flag_clr,
   output logic             pwm_out,
   output logic             pwm_out_bar,
   output logic             wrap_pulse,
   output logic             match_pulse,
   output logic             irq_flag,
   output logic             load_pending
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state, state_nxt;
   logic [WIDTH-1:0] count_q, duty_pend, duty_act, duty_nxt;
   logic             wrap, xfer;

   // The duty taking effect at a wrap is compared in that same cycle, so the
   // new period's first count already uses the new duty.
   always_comb begin
      wrap      = count_en && (count_in < count_q);
      xfer      = wrap && (duty_load || load_pending);
      duty_nxt  = duty_act;
      if (wrap && duty_load)
         duty_nxt = duty_in;
      else if (wrap && load_pending)
         duty_nxt = duty_pend;
      state_nxt = state;
      if (xfer)
         state_nxt = RUN;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         count_q      <= '0;
         duty_pend    <= '0;
         duty_act     <= '0;
         load_pending <= 1'b0;
         wrap_pulse   <= 1'b0;
         match_pulse  <= 1'b0;
         pwm_out      <= 1'b0;
         irq_flag     <= 1'b0;
      end else begin
         state    <= state_nxt;
         count_q  <= count_in;
         duty_act <= duty_nxt;
         if (duty_load)
            duty_pend <= duty_in;
         if (wrap)
            load_pending <= 1'b0;
         else if (duty_load)
            load_pending <= 1'b1;
         wrap_pulse  <= wrap;
         match_pulse <= (state_nxt == RUN) && count_en &&
                        (count_in == duty_nxt) && (count_in != count_q);
         // A stalled counter freezes the waveform.
         if (state_nxt == IDLE)
            pwm_out <= 1'b0;
         else if (count_en)
            pwm_out <= (count_in < duty_nxt);
         if (wrap)
            irq_flag <= 1'b1;
         else if (flag_clr)
            irq_flag <= 1'b0;
      end
   end

   assign pwm_out_bar = ~pwm_out;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen: a vector table of hand-computed cycles plus
// sequences for full periods, stalls, upstream reset and async block reset.
module tb_count_pwm_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] count_in = '0;
   logic       count_en = 1'b0;
   logic [7:0] duty_in = '0;
   logic       duty_load = 1'b0;
   logic       flag_clr = 1'b0;
   logic       pwm_out, pwm_out_bar, wrap_pulse, match_pulse, irq_flag, load_pending;

   int total = 0;
   int bad   = 0;

   count_pwm_gen #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .count_in(count_in), .count_en(count_en),
      .duty_in(duty_in), .duty_load(duty_load), .flag_clr(flag_clr),
      .pwm_out(pwm_out), .pwm_out_bar(pwm_out_bar), .wrap_pulse(wrap_pulse),
      .match_pulse(match_pulse), .irq_flag(irq_flag), .load_pending(load_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] cnt;
      logic       en, ld;
      logic [7:0] di;
      logic       clr;
      logic       pwm, wrp, mat, irq, pnd;
   } vec_t;

   vec_t vecs[35];

   function automatic vec_t mk(int cnt, int en, int ld, int di, int clr,
                               int pwm, int wrp, int mat, int irq, int pnd);
      vec_t v;
      v.cnt = cnt[7:0]; v.en = en[0]; v.ld = ld[0]; v.di = di[7:0]; v.clr = clr[0];
      v.pwm = pwm[0]; v.wrp = wrp[0]; v.mat = mat[0]; v.irq = irq[0]; v.pnd = pnd[0];
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
   task automatic step(input int cnt, input int en, input int ld, input int di, input int clr);
      count_in  = cnt[7:0];
      count_en  = en[0];
      duty_load = ld[0];
      duty_in   = di[7:0];
      flag_clr  = clr[0];
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input int pwm, input int wrp, input int mat,
                          input int irq, input int pnd);
      chk({nm, ".pwm"}, pwm_out, pwm);
      chk({nm, ".bar"}, pwm_out_bar, pwm == 0 ? 1 : 0);
      chk({nm, ".wrap"}, wrap_pulse, wrp);
      chk({nm, ".match"}, match_pulse, mat);
      chk({nm, ".irq"}, irq_flag, irq);
      chk({nm, ".pend"}, load_pending, pnd);
   endtask

   initial begin
      int nmatch;
      //               cnt en ld  di clr pwm wrp mat irq pnd
      vecs[0]  = mk(  0, 1, 0,   0, 0,  0,  0,  0,  0,  0);
      vecs[1]  = mk(  5, 1, 0,   0, 0,  0,  0,  0,  0,  0);
      vecs[2]  = mk(255, 1, 0,   0, 0,  0,  0,  0,  0,  0);
      vecs[3]  = mk(  0, 1, 0,   0, 0,  0,  1,  0,  1,  0);
      vecs[4]  = mk( 10, 1, 1,  64, 0,  0,  0,  0,  1,  1);
      vecs[5]  = mk( 20, 1, 0,   0, 0,  0,  0,  0,  1,  1);
      vecs[6]  = mk(  0, 1, 0,   0, 0,  1,  1,  0,  1,  0);
      vecs[7]  = mk( 63, 1, 0,   0, 0,  1,  0,  0,  1,  0);
      vecs[8]  = mk( 64, 1, 0,   0, 0,  0,  0,  1,  1,  0);
      vecs[9]  = mk( 64, 1, 0,   0, 0,  0,  0,  0,  1,  0);
      vecs[10] = mk( 65, 1, 0,   0, 1,  0,  0,  0,  0,  0);
      vecs[11] = mk( 66, 1, 1, 100, 0,  0,  0,  0,  0,  1);
      vecs[12] = mk( 67, 1, 1, 200, 0,  0,  0,  0,  0,  1);
      vecs[13] = mk(  0, 1, 0,   0, 0,  1,  1,  0,  1,  0);
      vecs[14] = mk(199, 1, 0,   0, 0,  1,  0,  0,  1,  0);
      vecs[15] = mk(200, 1, 0,   0, 0,  0,  0,  1,  1,  0);
      vecs[16] = mk(  0, 1, 1,  30, 1,  1,  1,  0,  1,  0);
      vecs[17] = mk( 29, 1, 0,   0, 0,  1,  0,  0,  1,  0);
      vecs[18] = mk( 30, 1, 0,   0, 0,  0,  0,  1,  1,  0);
      vecs[19] = mk( 31, 0, 0,   0, 0,  0,  0,  0,  1,  0);
      vecs[20] = mk(  0, 0, 0,   0, 0,  0,  0,  0,  1,  0);
      vecs[21] = mk(  1, 1, 0,   0, 0,  1,  0,  0,  1,  0);
      vecs[22] = mk( 29, 0, 0,   0, 0,  1,  0,  0,  1,  0);
      vecs[23] = mk( 30, 0, 0,   0, 0,  1,  0,  0,  1,  0);
      vecs[24] = mk( 30, 1, 0,   0, 0,  0,  0,  0,  1,  0);
      vecs[25] = mk(100, 1, 1,   0, 0,  0,  0,  0,  1,  1);
      vecs[26] = mk(255, 1, 0,   0, 0,  0,  0,  0,  1,  1);
      vecs[27] = mk(  0, 1, 0,   0, 0,  0,  1,  1,  1,  0);
      vecs[28] = mk(128, 1, 0,   0, 0,  0,  0,  0,  1,  0);
      vecs[29] = mk(254, 1, 1, 255, 0,  0,  0,  0,  1,  1);
      vecs[30] = mk(255, 1, 0,   0, 0,  0,  0,  0,  1,  1);
      vecs[31] = mk(  0, 1, 0,   0, 0,  1,  1,  0,  1,  0);
      vecs[32] = mk(254, 1, 0,   0, 0,  1,  0,  0,  1,  0);
      vecs[33] = mk(255, 1, 0,   0, 0,  0,  0,  1,  1,  0);
      vecs[34] = mk(  0, 1, 0,   0, 0,  1,  1,  0,  1,  0);

      // Reset state, checked with no clock edge involved.
      #3 reset = 1'b0;
      #1 chk_all("reset", 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         step(vecs[i].cnt, vecs[i].en, vecs[i].ld, vecs[i].di, vecs[i].clr);
         chk_all($sformatf("vec%0d", i), vecs[i].pwm, vecs[i].wrp, vecs[i].mat,
                 vecs[i].irq, vecs[i].pnd);
      end

      // Buffered load of 64 at count 10 while duty 255 is active, then one full period.
      for (int c = 1; c < 256; c++) begin
         step(c, 1, (c == 10) ? 1 : 0, 64, 0);
         chk_all($sformatf("ldper.c%0d", c), (c < 255) ? 1 : 0, 0, (c == 255) ? 1 : 0,
                 1, (c >= 10) ? 1 : 0);
      end
      for (int c = 0; c < 256; c++) begin
         step(c, 1, 0, 0, 0);
         chk_all($sformatf("d64.c%0d", c), (c < 64) ? 1 : 0, (c == 0) ? 1 : 0,
                 (c == 64) ? 1 : 0, 1, 0);
      end

      // Stall at count == duty: exactly one match, waveform frozen.
      nmatch = 0;
      for (int c = 0; c <= 64; c++) begin
         step(c, 1, 0, 0, 0);
         if (c >= 60) nmatch += match_pulse;
      end
      for (int k = 0; k < 20; k++) begin
         step(64, 0, 0, 0, 0);
         nmatch += match_pulse;
         chk($sformatf("stall%0d.pwm", k), pwm_out, 0);
      end
      step(64, 1, 0, 0, 0);
      nmatch += match_pulse;
      chk("stall.nmatch", nmatch, 1);

      // Upstream counter reset mid-period applies the pending duty.
      step(120, 1, 1, 50, 0);
      chk_all("up.ld", 0, 0, 0, 1, 1);
      step(0, 1, 0, 0, 0);
      chk_all("up.wrap", 1, 1, 0, 1, 0);
      step(50, 1, 0, 0, 0);
      chk_all("up.d50", 0, 0, 1, 1, 0);
      step(10, 1, 0, 0, 0);
      chk("up.c10.pwm", pwm_out, 1);
      step(11, 1, 1, 77, 0);
      chk_all("pre.rst", 1, 0, 0, 1, 1);

      // Block reset mid-cycle: outputs clear without a clock edge.
      #2 reset = 1'b0;
      #1 chk_all("async", 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      step(11, 1, 0, 0, 0);
      chk_all("rel", 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk_all("rel.wrap", 0, 1, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
